serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 op_a  input  WIDTH  addend A.
REQ-007 op_b  input  WIDTH  addend B.
REQ-008 cin  input  1  carry-in for the operation.
REQ-009 out_valid  output  1  result/cout valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  sum bits, (op_a+op_b+cin) mod 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; one state active at a time.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready capture op_a, op_b into shift registers, carry flop<=cin, bit counter<=0, go to RUN.
REQ-016 RUN: in_ready=0; each cycle drive the fulladder with a=A_sh[0], b=B_sh[0], ci=carry flop.
REQ-017 RUN, each edge: shift A_sh/B_sh right by one; shift sum into result register MSB (result shifts right); carry flop<=co; counter+1.
REQ-018 RUN SHALL last exactly WIDTH cycles; at the edge where counter==WIDTH-1 go to DONE; counter width $clog2(WIDTH), no wrap beyond WIDTH-1.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH+1 cycles after the acceptance edge (1 capture edge + WIDTH bit edges).
REQ-020 DONE: out_valid=1; result and cout SHALL hold stable while out_ready=0 (unlimited backpressure).
REQ-021 DONE with out_ready=1: handshake completes at that edge, go to IDLE; out_valid low next cycle.
REQ-022 No overlap: a new operand set SHALL not be accepted in RUN or DONE; in_valid there is ignored, op_a/op_b/cin may change freely.
REQ-023 After an output handshake the block SHALL spend at least one cycle in IDLE before the next acceptance; throughput one op per WIDTH+2 cycles.
REQ-024 result/cout SHALL retain last completed values in IDLE; consumers qualify only with out_valid.
REQ-025 Arithmetic: {cout,result} SHALL equal op_a+op_b+cin as captured, WIDTH+1-bit unsigned.

Reset
REQ-026 rst high at any edge, including mid-RUN or in DONE, SHALL force IDLE, discard the in-flight operation, and clear counter, carry flop, shift registers.
REQ-027 Reset values: in_ready=1, out_valid=0, busy=0, result=0, cout=0.
REQ-028 rst SHALL take priority over any simultaneous in_valid or out_ready handshake.

Structure
REQ-029 Package serial_adder_pkg SHALL hold the state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-030 Exactly one sub-module: the existing fulladder (ports a, b, ci, sum, co), instantiated once; all bit arithmetic SHALL go through it, no '+' operator on operands.
REQ-031 Controller logic (FSM, counter, shift registers, carry flop) SHALL be in serial_adder_ctrl itself.

Verification (WIDTH=8)
REQ-032 op_a=8'h00, op_b=8'h00, cin=0 -> out_valid 9 cycles after accept, result=8'h00, cout=0.
REQ-033 op_a=8'hFF, op_b=8'h01, cin=0 -> result=8'h00, cout=1; then 8'hA5+8'h5A+cin=1 -> result=8'h00, cout=1.
REQ-034 op_a=8'h3C, op_b=8'h41, cin=1, out_ready=0 for 5 cycles in DONE -> result=8'h7E, cout=0 held stable all 5 cycles, in_ready=0 throughout.
REQ-035 rst pulsed 4 cycles into RUN -> next cycle IDLE, in_ready=1, out_valid=0, result=0; subsequent 8'h10+8'h20+0 -> result=8'h30.
REQ-036 in_valid held high with two operand sets and out_ready=1 -> second accepted only after one IDLE cycle; both results correct; no extra out_valid pulses.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder controller:
//   - state_t       : controller states (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH : default operand/result width in bits
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// fulladder
//   Single-bit full adder; every bit of the serial sum passes through here.
//   Ports:
//     a, b  : addend bits
//     ci    : carry in
//     sum   : a ^ b ^ ci
//     co    : carry out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder: accepts one operand set, adds it LSB-first through a
//   single full adder over WIDTH cycles, then presents {cout, result} until
//   the consumer takes it.
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready is high only in IDLE; out_valid is high only in DONE
//   and, once raised, result/cout hold stable until out_ready is seen.
//
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid / in_ready : operand handshake (op_a, op_b, cin)
//     out_valid/out_ready : result handshake (result, cout)
//     busy                : high while in RUN or DONE
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_q;
  logic             fa_sum;
  logic             fa_co;

  fulladder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .ci  (carry),
    .sum (fa_sum),
    .co  (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      cout_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= op_a;
            b_sh     <= op_b;
            carry    <= cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so that after WIDTH shifts bit 0 of
          // the operands has landed in result[0].
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
          carry  <= fa_co;
          if (cnt == LAST) begin
            cnt       <= '0;
            cout_q    <= fa_co;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign result = res_sh;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int ov_rises = 0;
  logic ov_prev = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy)
  );

  // Count rising edges of out_valid, sampled away from the active edge.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) ov_rises++;
    ov_prev = out_valid;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present an operand set and return #1 after the acceptance edge.
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int n;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    cin      = ci;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Counts rising edges starting with the acceptance edge (edge 1) up to the
  // edge after which out_valid is seen high: capture + WIDTH bit edges = 9.
  task automatic wait_result(output int edges);
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // Full operation with out_ready already high: accept, wait, check, handshake.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic [W-1:0] exp_r, input logic exp_c);
    int e;
    send_op(a, b, ci);
    in_valid = 1'b0;
    op_a = W'($urandom_range(0, 255));
    op_b = W'($urandom_range(0, 255));
    cin  = 1'($urandom_range(0, 1));
    wait_result(e);
    check({tag, "_latency"}, e, W + 1);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_cout"}, cout, exp_c);
    check({tag, "_busy"}, busy, 1'b1);
    @(posedge clk); #1;
    check({tag, "_ov_low"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_retain"}, result, exp_r);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e;
    int rises0;
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_cout", cout, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    do_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op("a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    do_op("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    do_op("7f_80_c1", 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1);

    // Backpressure in DONE: 3C + 41 + 1 = 7E, no carry.
    out_ready = 1'b0;
    send_op(8'h3C, 8'h41, 1'b1);
    in_valid = 1'b0;
    wait_result(e);
    check("bp_latency", e, W + 1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op_a = W'($urandom_range(0, 255));
      op_b = W'($urandom_range(0, 255));
      check("bp_result", result, 8'h7E);
      check("bp_cout", cout, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ov_low", out_valid, 1'b0);
    check("bp_retain", result, 8'h7E);

    // Reset 4 cycles into RUN.
    send_op(8'hEE, 8'h77, 1'b1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_result", result, 8'h00);
    check("mid_rst_cout", cout, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    do_op("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // in_valid held high across two operand sets.
    rises0 = ov_rises;
    send_op(8'h12, 8'h34, 1'b0);
    op_a = 8'hC8; op_b = 8'h64; cin = 1'b1;   // second set, in_valid stays high
    wait_result(e);
    check("b2b1_latency", e, W + 1);
    check("b2b1_result", result, 8'h46);
    check("b2b1_cout", cout, 1'b0);
    @(posedge clk); #1;                        // output handshake edge
    check("b2b_idle_in_ready", in_ready, 1'b1);
    check("b2b_idle_ov", out_valid, 1'b0);
    check("b2b_idle_busy", busy, 1'b0);
    @(posedge clk); #1;                        // second acceptance edge
    check("b2b2_accepted", busy, 1'b1);
    check("b2b2_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_result(e);
    check("b2b2_latency", e, W + 1);
    check("b2b2_result", result, 8'h2D);
    check("b2b2_cout", cout, 1'b1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_ov_pulses", ov_rises - rises0, 2);
    check("b2b_end_ov", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
